// File: rtl/hilo_muldiv_seq.sv
// hilo_muldiv_seq: iterative multiply/divide unit for the execute stage.
// Takes MULT/MULTU/DIV/DIVU from E and runs one radix-2 step per cycle
// on the operand magnitudes, then applies a single sign-fix cycle. It stalls
// the front of the pipeline while busy and presents {hi,lo} with a one-cycle
// write strobe in DONE.
module hilo_muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_E,
    input  logic [1:0]           op_E,
    input  logic [WIDTH-1:0]     rs_E,
    input  logic [WIDTH-1:0]     rt_E,
    input  logic                 flush,
    output logic                 busy,
    output logic                 stall_E,
    output logic                 we_hilo,
    output logic [2*WIDTH-1:0]   hilo_d,
    output logic                 div_by_zero
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t               state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [WIDTH-1:0]     a_q;       // multiplicand or divisor magnitude
    logic [WIDTH-1:0]     hi_q;      // product high half / partial remainder
    logic [WIDTH-1:0]     lo_q;      // multiplier bits / dividend then quotient
    logic                 sa_q;      // rs operand was negative (signed ops only)
    logic                 sb_q;      // rt operand was negative (signed ops only)
    logic                 is_div_q;
    logic                 dbz_q;
    logic [2*WIDTH-1:0]   hilo_q;    // last committed {hi,lo}

    logic                 rs_neg;
    logic                 rt_neg;
    logic [WIDTH-1:0]     rs_mag;
    logic [WIDTH-1:0]     rt_mag;
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       div_sh;
    logic [WIDTH:0]       div_diff;
    logic                 div_ge;

    // Two's complement negate when neg is set, WIDTH bits, wrapping.
    function automatic logic [WIDTH-1:0] cond_neg_w(input logic [WIDTH-1:0] v,
                                                    input logic neg);
        return neg ? (~v + WIDTH'(1)) : v;
    endfunction

    // Two's complement negate when neg is set, 2*WIDTH bits, wrapping.
    function automatic logic [2*WIDTH-1:0] cond_neg_2w(input logic [2*WIDTH-1:0] v,
                                                       input logic neg);
        return neg ? (~v + (2*WIDTH)'(1)) : v;
    endfunction

    // Operand magnitudes and the single-step multiply / divide datapath.
    always_comb begin
        rs_neg   = op_E[0] & rs_E[WIDTH-1];
        rt_neg   = op_E[0] & rt_E[WIDTH-1];
        rs_mag   = cond_neg_w(rs_E, rs_neg);
        rt_mag   = cond_neg_w(rt_E, rt_neg);
        // shift-add: add multiplicand when the current multiplier bit is set
        mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
        // restoring divide: shift next dividend bit into the remainder
        div_sh   = {hi_q, lo_q[WIDTH-1]};
        div_diff = div_sh - {1'b0, a_q};
        div_ge   = (div_sh >= {1'b0, a_q});
    end

    // Sequencer FSM with its datapath registers and the committed HI/LO copy.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            is_div_q <= 1'b0;
            dbz_q    <= 1'b0;
            hilo_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_E && !flush) begin
                        sa_q     <= rs_neg;
                        sb_q     <= rt_neg;
                        is_div_q <= op_E[1];
                        cnt_q    <= '0;
                        if (op_E[1] && (rt_E == '0)) begin
                            // divide by zero skips straight to DONE with a fixed pattern
                            a_q     <= '0;
                            hi_q    <= rs_E;
                            lo_q    <= '1;
                            dbz_q   <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            a_q     <= op_E[1] ? rt_mag : rs_mag;
                            hi_q    <= '0;
                            lo_q    <= op_E[1] ? rs_mag : rt_mag;
                            dbz_q   <= 1'b0;
                            state_q <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (flush) begin
                        state_q <= S_IDLE;
                    end else begin
                        if (is_div_q) begin
                            hi_q <= div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
                            lo_q <= {lo_q[WIDTH-2:0], div_ge};
                        end else begin
                            hi_q <= mul_sum[WIDTH:1];
                            lo_q <= {mul_sum[0], lo_q[WIDTH-1:1]};
                        end
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(WIDTH-1)) begin
                            state_q <= S_FIX;
                        end
                    end
                end
                S_FIX: begin
                    if (flush) begin
                        state_q <= S_IDLE;
                    end else begin
                        if (is_div_q) begin
                            // quotient sign is the xor of signs, remainder follows dividend
                            lo_q <= cond_neg_w(lo_q, sa_q ^ sb_q);
                            hi_q <= cond_neg_w(hi_q, sa_q);
                        end else begin
                            {hi_q, lo_q} <= cond_neg_2w({hi_q, lo_q}, sa_q ^ sb_q);
                        end
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (!flush) begin
                        hilo_q <= {hi_q, lo_q};
                    end
                    dbz_q   <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Outputs: flush in DONE must suppress the write in the same cycle.
    always_comb begin
        busy        = (state_q != S_IDLE);
        stall_E     = ((state_q == S_IDLE) & start_E & ~flush & ~rst)
                    | (state_q == S_RUN) | (state_q == S_FIX);
        we_hilo     = (state_q == S_DONE) & ~flush & ~rst;
        div_by_zero = we_hilo & dbz_q;
        hilo_d      = hilo_q;
        if (we_hilo) begin
            hilo_d = {hi_q, lo_q};
        end
    end

endmodule

// File: tb/tb_hilo_muldiv_seq.sv
// Testbench for hilo_muldiv_seq: directed and random MULT/MULTU/DIV/DIVU
// operations checked cycle by cycle against an arithmetic reference model.
module tb_hilo_muldiv_seq;

    localparam int W = 32;

    logic            clk;
    logic            rst;
    logic            start_E;
    logic [1:0]      op_E;
    logic [W-1:0]    rs_E;
    logic [W-1:0]    rt_E;
    logic            flush;
    logic            busy;
    logic            stall_E;
    logic            we_hilo;
    logic [2*W-1:0]  hilo_d;
    logic            div_by_zero;

    int              checks;
    int              failures;
    logic [2*W-1:0]  hilo_model;

    hilo_muldiv_seq #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_E     (start_E),
        .op_E        (op_E),
        .rs_E        (rs_E),
        .rt_E        (rt_E),
        .flush       (flush),
        .busy        (busy),
        .stall_E     (stall_E),
        .we_hilo     (we_hilo),
        .hilo_d      (hilo_d),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [2*W-1:0] obs,
                         input logic [2*W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference result from plain arithmetic on the operation definitions.
    task automatic model(input logic [1:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, output logic [2*W-1:0] r,
                         output bit dbz);
        logic signed [2*W-1:0] x, y;
        logic signed [W-1:0]   sa, sb, q, rm;
        dbz = 1'b0;
        r   = '0;
        case (op)
            2'b00: r = {32'h0, a} * {32'h0, b};
            2'b01: begin
                x = $signed(a);
                y = $signed(b);
                r = x * y;
            end
            2'b10: begin
                if (b == 0) begin
                    dbz = 1'b1;
                    r   = {a, 32'hFFFF_FFFF};
                end else begin
                    r = {a % b, a / b};
                end
            end
            default: begin
                if (b == 0) begin
                    dbz = 1'b1;
                    r   = {a, 32'hFFFF_FFFF};
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    r = {32'h0, 32'h8000_0000};
                end else begin
                    sa = a;
                    sb = b;
                    q  = sa / sb;
                    rm = sa % sb;
                    r  = {rm, q};
                end
            end
        endcase
    endtask

    // Issue one op at cycle 0 and check every cycle up to DONE. abort_at >= 1
    // raises flush (or rst if use_rst) for that single cycle. Entered and left
    // 1ns after a rising edge.
    task automatic run_op(input logic [1:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int abort_at,
                          input bit use_rst, input bit idle_chk);
        logic [2*W-1:0] exp_res;
        bit             dbz;
        bit             aborted;
        bit             wr;
        int             lat;
        model(op, a, b, exp_res, dbz);
        lat     = dbz ? 1 : W + 2;
        aborted = 1'b0;
        start_E = 1'b1;
        op_E    = op;
        rs_E    = a;
        rt_E    = b;
        for (int c = 0; c <= lat; c++) begin
            if (c == abort_at) begin
                if (use_rst) rst = 1'b1;
                else         flush = 1'b1;
            end
            @(negedge clk);
            wr = (c == lat) && !(c == abort_at);
            check($sformatf("stall op%0d c%0d", op, c), 64'(stall_E), 64'(c < lat));
            check($sformatf("we op%0d c%0d", op, c), 64'(we_hilo), 64'(wr));
            check($sformatf("busy op%0d c%0d", op, c), 64'(busy), 64'(c >= 1));
            check($sformatf("dbz op%0d c%0d", op, c), 64'(div_by_zero), 64'(wr && dbz));
            if (c == lat || c == abort_at)
                check($sformatf("hilo op%0d c%0d", op, c), hilo_d, wr ? exp_res : hilo_model);
            @(posedge clk);
            #1;
            if (c == abort_at) begin
                rst     = 1'b0;
                flush   = 1'b0;
                aborted = 1'b1;
                break;
            end
        end
        start_E = 1'b0;
        if (!aborted)     hilo_model = exp_res;
        else if (use_rst) hilo_model = '0;
        if (idle_chk || aborted) begin
            @(negedge clk);
            check("idle busy", 64'(busy), 64'(0));
            check("idle stall", 64'(stall_E), 64'(0));
            check("idle we", 64'(we_hilo), 64'(0));
            check("idle dbz", 64'(div_by_zero), 64'(0));
            check("idle hilo", hilo_d, hilo_model);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [1:0]   rop;
        logic [W-1:0] ra, rb;
        checks     = 0;
        failures   = 0;
        hilo_model = '0;
        rst        = 1'b1;
        start_E    = 1'b1;
        op_E       = 2'b00;
        rs_E       = '0;
        rt_E       = '0;
        flush      = 1'b0;

        // reset state, start_E held high must not stall while rst is active
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst busy", 64'(busy), 64'(0));
        check("rst stall", 64'(stall_E), 64'(0));
        check("rst we", 64'(we_hilo), 64'(0));
        check("rst dbz", 64'(div_by_zero), 64'(0));
        check("rst hilo", hilo_d, 64'(0));
        @(posedge clk);
        #1;
        rst     = 1'b0;
        start_E = 1'b0;

        // directed cases
        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 1'b0, 1'b1);
        check("multu max", hilo_model, 64'hFFFF_FFFE_0000_0001);
        run_op(2'b01, 32'hFFFF_FFFD, 32'd5, -1, 1'b0, 1'b1);
        check("mult -3*5", hilo_model, 64'hFFFF_FFFF_FFFF_FFF1);
        run_op(2'b11, 32'hFFFF_FFF9, 32'd2, -1, 1'b0, 1'b1);
        check("div -7/2", hilo_model, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, -1, 1'b0, 1'b1);
        check("div ovf", hilo_model, 64'h0000_0000_8000_0000);
        run_op(2'b10, 32'h0000_1234, 32'd0, -1, 1'b0, 1'b1);
        check("divu by 0", hilo_model, 64'h0000_1234_FFFF_FFFF);

        // flush in RUN, then a normal divide
        run_op(2'b00, $urandom, $urandom, 10, 1'b0, 1'b1);
        run_op(2'b10, 32'd100, 32'd7, -1, 1'b0, 1'b1);
        check("divu 100/7", hilo_model, {32'd2, 32'd14});

        // flush while start_E is presented in IDLE: ignored
        start_E = 1'b1;
        op_E    = 2'b00;
        rs_E    = 32'd3;
        rt_E    = 32'd3;
        flush   = 1'b1;
        @(negedge clk);
        check("idle flush stall", 64'(stall_E), 64'(0));
        @(posedge clk);
        #1;
        start_E = 1'b0;
        flush   = 1'b0;
        @(negedge clk);
        check("idle flush busy", 64'(busy), 64'(0));
        @(posedge clk);
        #1;

        // reset mid-RUN, then flush on the DONE cycle
        run_op(2'b01, $urandom, $urandom, 20, 1'b1, 1'b1);
        run_op(2'b10, $urandom, $urandom | 32'h1, W + 2, 1'b0, 1'b1);
        check("flush done hilo", hilo_model, 64'(0));

        // random ops, alternating back-to-back issue and an idle gap
        for (int i = 0; i < 16; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            if (i % 3 == 1) rb = rb >> $urandom_range(0, 31);
            if (i % 5 == 4) rb = '0;
            run_op(rop, ra, rb, -1, 1'b0, (i % 2) == 0);
        end
        run_op(2'b01, 32'h8000_0000, 32'h8000_0000, -1, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
